// File: rtl/gf_mac_pipe.sv
// gf_mac_pipe: multi-lane GF(2^M) multiplier with an optional multiply-accumulate
// mode. Two registered stages share one global enable, so backpressure
// from the output side stalls the whole pipe, including the accumulators.
module gf_mac_pipe #(
  parameter int unsigned M         = 8,
  parameter int unsigned PRIM_POLY = 285,
  parameter int unsigned LANES     = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*M-1:0]   in_a,
  input  logic [LANES*M-1:0]   in_b,
  input  logic                 in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*M-1:0]   out_data,
  output logic                 out_acc
);

  localparam int unsigned W = LANES * M;

  // Reduction feedback term: the polynomial without its implicit x^M bit.
  localparam logic [M-1:0] POLY_LO = PRIM_POLY[M-1:0];

  // Polynomial-basis multiply: add shifted copies of a, reducing a by x each step.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) p = p ^ x;
      x = x[M-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
    end
    return p;
  endfunction

  logic         en;
  logic         accept;
  logic [W-1:0] prod;

  logic         s1_valid;
  logic         s1_mode;
  logic         s1_last;
  logic [W-1:0] s1_prod;

  logic [W-1:0] acc;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Per-lane products of the incoming operands; lanes are fully independent.
  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i*M +: M] = gf_mul(in_a[i*M +: M], in_b[i*M +: M]);
    end
  end

  // Stage 1: capture products and beat tags; an empty slot carries valid=0.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_mode  <= in_mode;
      s1_last  <= in_last;
      s1_prod  <= prod;
    end
  end

  // Stage 2: pass products through, fold into the accumulators, or emit the
  // burst sum and clear so a following burst starts from zero with no bubble.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_acc   <= 1'b0;
      acc       <= '0;
    end else if (en) begin
      if (!s1_valid) begin
        out_valid <= 1'b0;
      end else if (!s1_mode) begin
        out_data  <= s1_prod;
        out_acc   <= 1'b0;
        out_valid <= 1'b1;
      end else if (!s1_last) begin
        acc       <= acc ^ s1_prod;
        out_valid <= 1'b0;
      end else begin
        out_data  <= acc ^ s1_prod;
        out_acc   <= 1'b1;
        out_valid <= 1'b1;
        acc       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gf_mac_pipe.sv
// tb_gf_mac_pipe: directed and randomized checks of gf_mac_pipe against a
// carry-less-multiply-then-divide reference and an expected-output queue.
module tb_gf_mac_pipe;

  localparam int unsigned M     = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = LANES * M;
  localparam int unsigned PRIM  = 285;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_mode;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_acc;

  always #5 clk_in = ~clk_in;

  gf_mac_pipe #(.M(M), .PRIM_POLY(PRIM), .LANES(LANES)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full carry-less product, then long division by the polynomial.
  function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b);
    int unsigned p;
    p = 0;
    for (int i = 0; i < int'(M); i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 2 * int'(M) - 2; i >= int'(M); i--)
      if (((p >> i) & 1) != 0) p = p ^ (PRIM << (i - int'(M)));
    return p;
  endfunction

  function automatic logic [W-1:0] ref_lanes(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      t = ref_mul(32'(a[i*M +: M]), 32'(b[i*M +: M]));
      r[i*M +: M] = t[M-1:0];
    end
    return r;
  endfunction

  logic [W-1:0] m_acc;
  logic [W-1:0] mon_p;
  logic [W:0]   mon_e;
  logic [W:0]   expq[$];
  logic [W:0]   logq[$];
  int           xfer_cyc[$];
  int           acc_cyc[$];
  int           cyc = 0;
  logic         stream_chk = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor at the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge clk_in) begin
    if (!rst_n) begin
      m_acc = '0;
      expq.delete();
    end else begin
      if (stream_chk) chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        mon_p = ref_lanes(in_a, in_b);
        if (!in_mode) begin
          expq.push_back({1'b0, mon_p});
        end else begin
          m_acc = m_acc ^ mon_p;
          if (in_last) begin
            expq.push_back({1'b1, m_acc});
            m_acc = '0;
          end
        end
      end
      if (out_valid && out_ready) begin
        xfer_cyc.push_back(cyc);
        logq.push_back({out_acc, out_data});
        if (expq.size() == 0) begin
          chk("sb_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("sb_output", 64'({out_acc, out_data}), 64'(mon_e));
        end
      end
    end
  end

  function automatic logic [W:0] log_at(input int k);
    if (logq.size() > k) return logq[k];
    return '1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[i*M +: M] = ($urandom_range(0, 3) == 0) ? '0 : M'($urandom_range(0, (1 << M) - 1));
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic mode, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_last  = last;
    @(negedge clk_in);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk_in);
    end
    if (guard >= 200) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk_in);
    #1;
    in_valid = 1'b0;
  endtask

  logic [W-1:0] held;
  logic         rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_acc",   64'(out_acc),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // Single multiply beat: visible after the second edge, for one cycle.
    logq.delete();
    send(32'h001D8002, 32'hFF020202, 1'b0, 1'b0);
    chk("t1_lat_s1", 64'(out_valid), 64'd0);
    idle(1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data",  64'(out_data),  64'h003A1D04);
    chk("t1_acc",   64'(out_acc),   64'd0);
    idle(1);
    chk("t1_pulse", 64'(out_valid), 64'd0);

    // Accumulate burst, then a single-beat burst showing the clear.
    logq.delete();
    send(32'h02, 32'h02, 1'b1, 1'b0);
    send(32'h80, 32'h02, 1'b1, 1'b0);
    send(32'h03, 32'h01, 1'b1, 1'b1);
    idle(4);
    chk("t2_count", 64'(logq.size()), 64'd1);
    chk("t2_sum",   64'(log_at(0)),   64'h1_0000001A);
    logq.delete();
    send(32'h01, 32'h05, 1'b1, 1'b1);
    idle(4);
    chk("t2b_count", 64'(logq.size()), 64'd1);
    chk("t2b_sum",   64'(log_at(0)),   64'h1_00000005);

    // Back-to-back multiply stream at full rate.
    logq.delete();
    xfer_cyc.delete();
    acc_cyc.delete();
    stream_chk = 1'b1;
    for (int i = 0; i < 64; i++) send(rand_word(), rand_word(), 1'b0, 1'($urandom_range(0, 1)));
    stream_chk = 1'b0;
    idle(4);
    chk("stream_count", 64'(xfer_cyc.size()), 64'd64);
    if (xfer_cyc.size() == 64 && acc_cyc.size() == 64) begin
      chk("stream_latency", 64'(xfer_cyc[0] - acc_cyc[0]), 64'd2);
      chk("stream_rate",    64'(xfer_cyc[63] - xfer_cyc[0]), 64'd63);
    end

    // Output stall with input pressure.
    logq.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) send(rand_word(), rand_word(), 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk_in);
        #1;
        out_ready = 1'b0;
        held = out_data;
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
          @(posedge clk_in);
          #1;
          chk("bp_hold",     64'(out_data), 64'(held));
          chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_count", 64'(logq.size()), 64'd12);

    // Reset in the middle of a burst discards the partial sum.
    send(rand_word() | 32'h01, rand_word() | 32'h01, 1'b1, 1'b0);
    send(rand_word() | 32'h01, rand_word() | 32'h01, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    logq.delete();
    send(32'h07, 32'h01, 1'b1, 1'b1);
    idle(4);
    chk("rst2_count", 64'(logq.size()), 64'd1);
    chk("rst2_sum",   64'(log_at(0)),   64'h1_00000007);

    // Multiply beat interleaved inside a burst.
    logq.delete();
    send(32'h02, 32'h02, 1'b1, 1'b0);
    send(32'h02, 32'h03, 1'b0, 1'b0);
    send(32'h01, 32'h01, 1'b1, 1'b1);
    idle(4);
    chk("mix_count", 64'(logq.size()), 64'd2);
    chk("mix_prod",  64'(log_at(0)),   64'h0_00000006);
    chk("mix_sum",   64'(log_at(1)),   64'h1_00000005);

    // Random mix of modes, gaps and output backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          send(rand_word(), rand_word(), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0);
        end
        send(rand_word(), rand_word(), 1'b1, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_in);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    idle(8);
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
